// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: operation codes, FSM states
// and the legal-opcode decoder.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 6;
  localparam int CNT_W  = 4;

  localparam logic [SEL_W-1:0] SEL_ADD = 6'h20;
  localparam logic [SEL_W-1:0] SEL_SUB = 6'h22;
  localparam logic [SEL_W-1:0] SEL_AND = 6'h24;
  localparam logic [SEL_W-1:0] SEL_OR  = 6'h25;
  localparam logic [SEL_W-1:0] SEL_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // True for the five opcodes the ALU implements.
  function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
    logic ok;
    case (sel)
      SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_SLT: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu32_sequencer.sv
// Issue-side controller for the combinational 32-bit ripple ALU: accepts a
// request, holds the ALU pins stable for SETTLE_CYCLES, captures the result
// and flags, and returns them over a valid/ready response channel.
module alu32_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [SEL_W-1:0]  req_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              alu_c_in,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic              alu_c_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_ovf,
  output logic              rsp_err
);

  // Counter preload: the DRIVE state lasts exactly SETTLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [SEL_W-1:0]    r_alu_sel;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic                r_carry;
  logic                r_ovf;
  logic                r_err;
  logic                w_accept;
  logic                w_legal;
  logic                w_capture;
  logic                w_rsp_fire;

  // Signed overflow: ADD overflows when like-signed operands give a result of
  // the other sign; SUB when unlike-signed operands flip the sign of A.
  function automatic logic calc_ovf(input logic [SEL_W-1:0] sel,
                                    input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] sum);
    logic ovf;
    case (sel)
      SEL_ADD: ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      SEL_SUB: ovf = (a[DATA_W-1] != b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      default: ovf = 1'b0;
    endcase
    return ovf;
  endfunction

  // Carry is only meaningful for ADD/SUB; SLT also uses the adder but its
  // carry-out is an internal detail and is masked.
  function automatic logic calc_carry(input logic [SEL_W-1:0] sel, input logic c_out);
    return ((sel == SEL_ADD) || (sel == SEL_SUB)) ? c_out : 1'b0;
  endfunction

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_legal    = sel_is_legal(req_sel);
  assign w_capture  = (r_state == ST_DRIVE) && (r_cnt == '0);
  assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready;

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign alu_c_in   = r_alu_sel[1];
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_carry  = r_carry;
  assign rsp_ovf    = r_ovf;
  assign rsp_err    = r_err;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)   w_state_nxt = w_legal ? ST_DRIVE : ST_RESP;
      ST_DRIVE: if (w_capture)  w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_fire) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Settle counter: preloaded on a legal accept, counts down through DRIVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept && w_legal) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == ST_DRIVE) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Stage p0: ALU pin registers, loaded only by a legal accept so that the
  // pins never move for an illegal request or outside DRIVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else if (w_accept && w_legal) begin
      r_alu_a   <= req_a;
      r_alu_b   <= req_b;
      r_alu_sel <= req_sel;
    end
  end

  // Stage p1: response capture, either the settled ALU outputs or an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b1;
    end else if (w_capture) begin
      r_result <= alu_sum;
      r_zero   <= (alu_sum == '0);
      r_carry  <= calc_carry(r_alu_sel, alu_c_out);
      r_ovf    <= calc_ovf(r_alu_sel, r_alu_a, r_alu_b, alu_sum);
      r_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu32_sequencer.sv
// Directed bench for alu32_sequencer with a behavioural ripple-ALU model
// connected to the ALU pins.
module tb_alu32_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [5:0]  req_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_sel;
  logic        alu_c_in;
  logic [31:0] alu_sum;
  logic        alu_c_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        rsp_ovf;
  logic        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu32_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c_in(alu_c_in),
    .alu_sum(alu_sum), .alu_c_out(alu_c_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  // Behavioural ALU: adder path uses B inverted when SEL[1] is set, with C_IN.
  logic [32:0] alu_full;
  always_comb begin
    alu_full  = '0;
    alu_sum   = '0;
    alu_c_out = 1'b0;
    case (alu_sel)
      SEL_AND: alu_sum = alu_a & alu_b;
      SEL_OR:  alu_sum = alu_a | alu_b;
      SEL_ADD, SEL_SUB, SEL_SLT: begin
        alu_full  = {1'b0, alu_a} + {1'b0, (alu_sel[1] ? ~alu_b : alu_b)} + {32'd0, alu_c_in};
        alu_c_out = alu_full[32];
        if (alu_sel == SEL_SLT) alu_sum = {31'd0, ($signed(alu_a) < $signed(alu_b))};
        else                    alu_sum = alu_full[31:0];
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [5:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
    logic        e;
    logic        cin;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present a request, wait for its accept edge, then count cycles to rsp_valid.
  task automatic issue_and_wait(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output logic cin_seen);
    int guard;
    @(negedge clk);
    req_sel   = sel;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    cin_seen = 1'b0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      cin_seen = alu_c_in;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic        cin_seen;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [5:0]  last_sel;

    vecs[0] = '{SEL_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[1] = '{SEL_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3};
    vecs[2] = '{SEL_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3};
    vecs[3] = '{SEL_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[4] = '{SEL_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[5] = '{SEL_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[6] = '{SEL_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3};
    vecs[7] = '{SEL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[8] = '{6'h3F,   32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[9] = '{SEL_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3};

    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("reset_alu_a", alu_a, 32'd0);
    check_val("reset_alu_sel", {26'd0, alu_sel}, 32'd0);
    check_val("reset_rsp_result", rsp_result, 32'd0);
    check_val("reset_rsp_err", {31'd0, rsp_err}, 32'd0);

    last_a = '0; last_b = '0; last_sel = '0;
    for (int i = 0; i < 10; i++) begin
      issue_and_wait(vecs[i].sel, vecs[i].a, vecs[i].b, lat, cin_seen);
      check_val($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check_val($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
      check_val($sformatf("v%0d_zero", i), {31'd0, rsp_zero}, {31'd0, vecs[i].z});
      check_val($sformatf("v%0d_carry", i), {31'd0, rsp_carry}, {31'd0, vecs[i].c});
      check_val($sformatf("v%0d_ovf", i), {31'd0, rsp_ovf}, {31'd0, vecs[i].o});
      check_val($sformatf("v%0d_err", i), {31'd0, rsp_err}, {31'd0, vecs[i].e});
      if (vecs[i].e) begin
        check_val($sformatf("v%0d_pins_a", i), alu_a, last_a);
        check_val($sformatf("v%0d_pins_b", i), alu_b, last_b);
        check_val($sformatf("v%0d_pins_sel", i), {26'd0, alu_sel}, {26'd0, last_sel});
      end else begin
        check_val($sformatf("v%0d_c_in", i), {31'd0, cin_seen}, {31'd0, vecs[i].cin});
        last_a = vecs[i].a; last_b = vecs[i].b; last_sel = vecs[i].sel;
      end
      handshake();
    end

    // Backpressure: response stalled 5 cycles while a second request waits.
    @(negedge clk);
    req_sel = SEL_ADD; req_a = 32'd10; req_b = 32'd20; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_sel = SEL_SUB; req_a = 32'd100; req_b = 32'd1;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check_val("stall_latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("stall%0d_result", k), rsp_result, 32'd30);
      check_val($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
      check_val($sformatf("stall%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      check_val($sformatf("stall%0d_alu_a", k), alu_a, 32'd10);
      @(negedge clk);
    end
    handshake();
    @(negedge clk);
    check_val("stall_after_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("stall_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check_val("second_latency", 32'(lat), 32'd3);
    check_val("second_result", rsp_result, 32'd99);
    check_val("second_carry", {31'd0, rsp_carry}, 32'd1);
    handshake();

    // Reset pulse during DRIVE aborts the operation.
    @(negedge clk);
    req_sel = SEL_ADD; req_a = 32'd7; req_b = 32'd8; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_val("abort_in_drive", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("abort_alu_a", alu_a, 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_val("abort_no_response", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
